// File: rtl/multicycle_sequencer.sv
// Multicycle control FSM for a 19-bit instruction word, with memory wait timeout.
// Optional macro ILLEGAL_TRAP_EN: undefined encodings halt instead of acting as NOP.
module multicycle_sequencer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [18:0] instr,
  input  logic        mem_ready,
  input  logic        zero,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel_data,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic [1:0]  alu_code,
  output logic        i_flag,
  output logic        j_flag,
  output logic [2:0]  state,
  output logic        mem_err
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_e;

`ifdef ILLEGAL_TRAP_EN
  localparam state_e ILL_NEXT = S_HALT;
`else
  localparam state_e ILL_NEXT = S_FETCH;
`endif

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q;
  state_e      next_state;
  logic [18:0] ir_q;
  logic [7:0]  wait_cnt;

  logic [1:0]  ir_type;
  logic [1:0]  ir_code;
  logic [2:0]  ir_funct;
  logic        unused_ir;

  assign ir_type   = ir_q[18:17];
  assign ir_code   = ir_q[16:15];
  assign ir_funct  = ir_q[2:0];
  assign unused_ir = ^ir_q[14:3];

  logic is_r;
  logic is_i;
  logic is_b;
  logic is_j;
  logic is_lw;
  logic is_sw;
  logic is_beq;
  logic is_ill;

  always_comb begin
    is_r   = (ir_type == 2'b00);
    is_i   = (ir_type == 2'b01);
    is_b   = (ir_type == 2'b10);
    is_j   = (ir_type == 2'b11);
    is_lw  = is_i && (ir_code == 2'b10);
    is_sw  = is_b && (ir_code == 2'b00);
    is_beq = is_b && (ir_code == 2'b10);
    is_ill = (is_r && (ir_funct == 3'b011 ||
                       ir_funct == 3'b110)) ||
             (is_b && (ir_code == 2'b11));
  end

  logic [1:0] dec_alu;
  logic       dec_i;
  logic       dec_j;

  always_comb begin
    dec_alu = 2'b00;
    dec_i   = is_i || is_b;
    dec_j   = is_j;
    unique case (1'b1)
      is_r: begin
        unique case (ir_funct)
          3'b010:  dec_alu = 2'b01;
          3'b100:  dec_alu = 2'b10;
          3'b101:  dec_alu = 2'b11;
          default: dec_alu = 2'b00;
        endcase
      end
      is_i: begin
        if (ir_code == 2'b01)
          dec_alu = 2'b10;
      end
      is_b: begin
        if (is_beq)
          dec_alu = 2'b01;
      end
      is_j: dec_alu = 2'b00;
      default: dec_alu = 2'b00;
    endcase
  end

  logic waiting;
  logic timed_out;

  assign waiting   = (state_q == S_FETCH ||
                      state_q == S_MEM) && !mem_ready;
  assign timed_out = waiting && (wait_cnt == TO_LAST);

  // State register, IR, wait counter and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      ir_q     <= '0;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state_q <= next_state;
      if (state_q == S_FETCH && mem_ready)
        ir_q <= instr;
      if (next_state != state_q)
        wait_cnt <= '0;
      else if (waiting)
        wait_cnt <= wait_cnt + 8'd1;
      if (next_state == S_HALT)
        mem_err <= 1'b1;
    end
  end

  always_comb begin
    next_state = state_q;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready)
          next_state = S_DECODE;
        else if (timed_out)
          next_state = S_HALT;
      end
      S_DECODE: next_state = S_EXEC;
      S_EXEC: begin
        if (is_ill)
          next_state = ILL_NEXT;
        else if (is_lw || is_sw)
          next_state = S_MEM;
        else if (is_b || is_j)
          next_state = S_FETCH;
        else
          next_state = S_WB;
      end
      S_MEM: begin
        if (mem_ready)
          next_state = is_sw ? S_FETCH : S_WB;
        else if (timed_out)
          next_state = S_HALT;
      end
      S_WB:   next_state = S_FETCH;
      S_HALT: next_state = S_HALT;
      default: next_state = S_FETCH;
    endcase
  end

  // Outputs are held low for as long as reset is asserted
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_sel_data = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'b00;
    reg_write    = 1'b0;
    alu_code     = 2'b00;
    i_flag       = 1'b0;
    j_flag       = 1'b0;
    if (!rst) begin
      unique case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we = 1'b1;
            pc_we = 1'b1;
          end
        end
        S_EXEC: begin
          alu_code = dec_alu;
          i_flag   = dec_i;
          j_flag   = dec_j;
          if (is_beq && zero) begin
            pc_we  = 1'b1;
            pc_src = 2'b01;
          end
          if (is_j) begin
            pc_we     = 1'b1;
            pc_src    = 2'b10;
            reg_write = 1'b1;
          end
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_sel_data = 1'b1;
          i_flag       = 1'b1;
          mem_we       = is_sw;
        end
        S_WB: begin
          reg_write = 1'b1;
          alu_code  = dec_alu;
          i_flag    = dec_i;
          j_flag    = dec_j;
        end
        default: ;
      endcase
    end
  end

  assign state = rst ? 3'd0 : state_q;

endmodule
